// File: rtl/dut_alu_pipe.sv
// Two-stage pipelined A/B arithmetic unit: MUL, ADD, SUB and saturating MAC
// with valid/ready handshaking and full backpressure on the result side.
module dut_alu_pipe #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  i_reset,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_W-1:0]     i_data_A,
   input  logic [DATA_W-1:0]     i_data_B,
   input  logic [1:0]            i_sel_op,
   input  logic                  i_acc_clr,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [2*DATA_W-1:0]   o_data,
   output logic                  o_sat
);

   localparam int DW = 2 * DATA_W;

   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_MAC = 2'b11;

   logic              en;
   logic              v1_q;
   logic [DATA_W-1:0] a1_q, b1_q;
   logic [1:0]        op1_q;
   logic              clr1_q;

   logic              valid_q;
   logic [DW-1:0]     data_q, data_d;
   logic [DW-1:0]     acc_q, acc_d;
   logic              sat_q, sat_d;

   logic [DW-1:0]     aExt, bExt, prod;
   logic [DATA_W:0]   sum, diff;
   logic [DW:0]       macSum;

   // The whole pipe advances unless a held result is waiting on downstream.
   assign en      = !(valid_q && !i_ready);
   assign o_ready = en;
   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_sat   = sat_q;

   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         v1_q   <= 1'b0;
         a1_q   <= '0;
         b1_q   <= '0;
         op1_q  <= OP_MUL;
         clr1_q <= 1'b0;
      end else if (en) begin
         v1_q   <= i_valid;
         a1_q   <= i_data_A;
         b1_q   <= i_data_B;
         op1_q  <= i_sel_op;
         clr1_q <= i_acc_clr;
      end
   end

   assign aExt   = {{DATA_W{1'b0}}, a1_q};
   assign bExt   = {{DATA_W{1'b0}}, b1_q};
   assign prod   = aExt * bExt;
   assign sum    = {1'b0, a1_q} + {1'b0, b1_q};
   assign diff   = {1'b0, a1_q} - {1'b0, b1_q};
   assign macSum = {1'b0, acc_q} + {1'b0, prod};

   // Accumulator only ever changes here, so back-to-back MACs need no bubbles.
   always_comb begin
      acc_d  = acc_q;
      sat_d  = sat_q;
      data_d = data_q;
      unique case (op1_q)
         OP_MUL: data_d = prod;
         OP_ADD: data_d = {{(DATA_W-1){1'b0}}, sum};
         OP_SUB: data_d = {{(DATA_W-1){diff[DATA_W]}}, diff};
         OP_MAC: begin
            if (clr1_q) begin
               acc_d = prod;
               sat_d = 1'b0;
            end else if (macSum[DW]) begin
               acc_d = '1;
               sat_d = 1'b1;
            end else begin
               acc_d = macSum[DW-1:0];
            end
            data_d = acc_d;
         end
         default: data_d = prod;
      endcase
   end

   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         acc_q   <= '0;
         sat_q   <= 1'b0;
      end else if (en) begin
         valid_q <= v1_q;
         if (v1_q) begin
            data_q <= data_d;
            if (op1_q == OP_MAC) begin
               acc_q <= acc_d;
               sat_q <= sat_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_dut_alu_pipe.sv
// Directed self-checking bench for dut_alu_pipe (DATA_W=8) using immediate
// assertions against hand-computed results.
`timescale 1ns/1ps
module tb_dut_alu_pipe;

   localparam int DATA_W = 8;

   logic                clk;
   logic                rstN;
   logic                inValid;
   logic                outReady;
   logic [DATA_W-1:0]   dataA;
   logic [DATA_W-1:0]   dataB;
   logic [1:0]          selOp;
   logic                accClr;
   logic                outValid;
   logic                downReady;
   logic [2*DATA_W-1:0] outData;
   logic                outSat;

   int checks;
   int failures;

   dut_alu_pipe #(.DATA_W(DATA_W)) dut (
      .clk      (clk),
      .i_reset  (rstN),
      .i_valid  (inValid),
      .o_ready  (outReady),
      .i_data_A (dataA),
      .i_data_B (dataB),
      .i_sel_op (selOp),
      .i_acc_clr(accClr),
      .o_valid  (outValid),
      .i_ready  (downReady),
      .o_data   (outData),
      .o_sat    (outSat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle away from it before driving or sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] op, input int a, input int b,
                                input logic clr);
      inValid = 1'b1;
      selOp   = op;
      dataA   = DATA_W'(a);
      dataB   = DATA_W'(b);
      accClr  = clr;
   endtask

   // One isolated transaction: accept edge, then result edge.
   task automatic sendOne(input string tag, input logic [1:0] op, input int a,
                          input int b, input logic clr, input logic [15:0] expData,
                          input logic expSat);
      applyStimulus(op, a, b, clr);
      tick();
      inValid = 1'b0;
      tick();
      checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
      checkOutput({tag, "_data"}, 32'(outData), 32'(expData));
      checkOutput({tag, "_sat"}, 32'(outSat), 32'(expSat));
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rstN      = 1'b0;
      inValid   = 1'b0;
      dataA     = '0;
      dataB     = '0;
      selOp     = 2'b00;
      accClr    = 1'b0;
      downReady = 1'b1;

      // Reset and idle
      repeat (3) tick();
      rstN = 1'b1;
      tick();
      checkOutput("rst_valid", 32'(outValid), 32'd0);
      checkOutput("rst_data", 32'(outData), 32'h0000);
      checkOutput("rst_sat", 32'(outSat), 32'd0);
      checkOutput("rst_ready", 32'(outReady), 32'd1);

      // Basic ops back-to-back
      applyStimulus(2'b00, 200, 150, 1'b0);
      tick();
      checkOutput("lat_first_not_yet", 32'(outValid), 32'd0);
      applyStimulus(2'b01, 255, 255, 1'b0);
      tick();
      checkOutput("mul_valid", 32'(outValid), 32'd1);
      checkOutput("mul_data", 32'(outData), 32'h7530);
      applyStimulus(2'b10, 5, 7, 1'b0);
      tick();
      checkOutput("add_valid", 32'(outValid), 32'd1);
      checkOutput("add_data", 32'(outData), 32'h01FE);
      inValid = 1'b0;
      tick();
      checkOutput("sub_valid", 32'(outValid), 32'd1);
      checkOutput("sub_data", 32'(outData), 32'hFFFE);
      tick();
      checkOutput("basic_drain", 32'(outValid), 32'd0);

      // MAC saturation
      sendOne("mac_clr", 2'b11, 200, 200, 1'b1, 16'h9C40, 1'b0);
      sendOne("mac_sat", 2'b11, 200, 200, 1'b0, 16'hFFFF, 1'b1);
      sendOne("add_keep", 2'b01, 1, 1, 1'b0, 16'h0002, 1'b1);
      sendOne("mac_restart", 2'b11, 3, 4, 1'b1, 16'h000C, 1'b0);
      tick();

      // Backpressure: 4 MULs, downstream stalls 3 cycles after first result
      applyStimulus(2'b00, 1, 1, 1'b0);
      tick();
      applyStimulus(2'b00, 2, 2, 1'b0);
      tick();
      checkOutput("bp_first_valid", 32'(outValid), 32'd1);
      checkOutput("bp_first_data", 32'(outData), 32'h0001);
      downReady = 1'b0;
      #1;
      checkOutput("bp_ready_low", 32'(outReady), 32'd0);
      applyStimulus(2'b00, 3, 3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("bp_stall%0d_ready", i), 32'(outReady), 32'd0);
         checkOutput($sformatf("bp_stall%0d_valid", i), 32'(outValid), 32'd1);
         checkOutput($sformatf("bp_stall%0d_data", i), 32'(outData), 32'h0001);
      end
      downReady = 1'b1;
      #1;
      checkOutput("bp_release_ready", 32'(outReady), 32'd1);
      checkOutput("bp_res1", 32'(outData), 32'h0001);
      tick();
      applyStimulus(2'b00, 4, 4, 1'b0);
      checkOutput("bp_res2_valid", 32'(outValid), 32'd1);
      checkOutput("bp_res2", 32'(outData), 32'h0004);
      tick();
      inValid = 1'b0;
      checkOutput("bp_res3_valid", 32'(outValid), 32'd1);
      checkOutput("bp_res3", 32'(outData), 32'h0009);
      tick();
      checkOutput("bp_res4_valid", 32'(outValid), 32'd1);
      checkOutput("bp_res4", 32'(outData), 32'h0010);
      tick();
      checkOutput("bp_no_dup", 32'(outValid), 32'd0);

      // Reset mid-flight
      applyStimulus(2'b11, 10, 10, 1'b1);
      tick();
      inValid = 1'b0;
      rstN    = 1'b0;
      #1;
      checkOutput("mid_rst_valid", 32'(outValid), 32'd0);
      tick();
      tick();
      rstN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("post_rst%0d_valid", i), 32'(outValid), 32'd0);
      end
      sendOne("mac_after_rst", 2'b11, 2, 3, 1'b0, 16'h0006, 1'b0);
      tick();

      // Idle inputs ignored
      inValid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         dataA  = DATA_W'($urandom_range(255, 0));
         dataB  = DATA_W'($urandom_range(255, 0));
         selOp  = 2'($urandom_range(3, 0));
         accClr = 1'($urandom_range(1, 0));
         tick();
         checkOutput($sformatf("idle%0d_valid", i), 32'(outValid), 32'd0);
      end
      sendOne("mac_after_idle", 2'b11, 1, 1, 1'b0, 16'h0007, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/dut_alu_pipe.md
Name: dut_alu_pipe

Overview:
Parametrised, pipelined successor to the slow-domain A/B arithmetic DUT. It accepts two DATA_W-bit operands and an opcode under a valid/ready handshake. The supported operations are multiply, add, subtract and saturating multiply-accumulate. Results are 2*DATA_W bits wide and arrive after a fixed two-cycle latency, with full backpressure support. It sits on the slow clock, in the same position as the existing slow-interface DUT.

Parameters:
DATA_W, 8, operand width in bits (>=2); result and accumulator width is 2*DATA_W.

Ports:
clk  input  1  slow-domain clock; all logic on rising edge.
i_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
i_valid  input  1  input operands/opcode valid.
o_ready  output  1  block can accept input this cycle.
i_data_A  input  DATA_W  operand A, unsigned.
i_data_B  input  DATA_W  operand B, unsigned.
i_sel_op  input  2  opcode: 00 MUL, 01 ADD, 10 SUB, 11 MAC.
i_acc_clr  input  1  sampled with a MAC transaction; restarts the accumulator and clears o_sat.
o_valid  output  1  result valid.
i_ready  input  1  downstream accepts the result.
o_data  output  2*DATA_W  result.
o_sat  output  1  sticky flag: accumulator saturated.

Behaviour:
- Reset (i_reset=0, async assert, sync-safe deassert): stage valids=0, o_valid=0, o_data=0, accumulator=0, o_sat=0. o_ready=1 while out of reset.
- Pipeline enable: en = !(o_valid && !i_ready). o_ready = en; this is combinational from o_valid/i_ready.
- Accept: a transaction is accepted when i_valid && o_ready.
- Stage 1 (when en): latches A, B, op, acc_clr, and v1 = i_valid && o_ready.
- Stage 2 (when en): computes from the stage-1 registers and loads o_data; o_valid <= v1.
- Latency: exactly 2 clk edges from acceptance to o_valid=1, absent stalls.
- Throughput: 1 transaction/cycle with i_ready held high.
- Stall: when en=0, all pipeline registers, the accumulator and o_sat hold. o_data stays stable while o_valid && !i_ready.
- Bubbles: bubbles are not squashed; an empty stage 1 still occupies its slot.
- MUL: o_data = A*B, full 2*DATA_W product.
- ADD: o_data = zero-extended A+B, DATA_W+1 significant bits.
- SUB: o_data = A-B in two's complement, sign-extended to 2*DATA_W. Example (DATA_W=8): 5-7 = 0xFFFE.
- MAC:
  - p = A*B; the accumulator is 2*DATA_W bits, unsigned.
  - If acc_clr=1: next = p, and o_sat is cleared.
  - Otherwise: next = acc + p, computed in 2*DATA_W+1 bits. If it exceeds 2^(2*DATA_W)-1, the accumulator becomes all-ones and o_sat=1.
  - Once saturated, the accumulator stays all-ones on further non-clear MACs.
  - o_data = new accumulator value.
  - The accumulator updates only in stage 2, only on a valid MAC, and only when en=1.
- Non-MAC ops never modify the accumulator or o_sat.
- o_sat: remains 1 until a MAC with acc_clr=1 completes stage 2, or until reset.
- Back-to-back MACs: each uses the accumulator value left by the previous MAC; no hazard bubbles are required, because only stage 2 touches the accumulator.
- Reset mid-operation: in-flight transactions are discarded, with no output after reset release. The accumulator and o_sat return to 0.
- Inputs while i_valid=0 are don't-care and must not affect any state.

Test Plan:
- Reset and idle: hold i_reset=0 for 3 cycles, then release with i_valid=0 -> o_valid=0, o_data=0x0000, o_sat=0, o_ready=1.
- Basic ops, DATA_W=8, i_ready=1: send MUL 200,150 / ADD 255,255 / SUB 5,7 back-to-back -> o_valid on cycles 2, 3 and 4 after the first accept, with o_data = 0x7530, 0x01FE, 0xFFFE.
- MAC saturation:
  - Send MAC 200,200 with acc_clr=1 -> o_data 0x9C40, o_sat=0.
  - Send MAC 200,200 with acc_clr=0 -> o_data 0xFFFF, o_sat=1.
  - Send ADD 1,1 -> o_data 0x0002, o_sat stays 1.
  - Send MAC 3,4 with acc_clr=1 -> o_data 0x000C, o_sat=0.
- Backpressure: stream 4 MULs (1*1 ... 4*4) with i_ready=0 for 3 cycles after the first o_valid.
  - During the stall: o_ready=0, and o_data holds 0x0001.
  - After releasing i_ready: the results 0x0001, 0x0004, 0x0009, 0x0010 appear in order, with none lost or duplicated.
- Reset mid-flight: accept MAC 10,10 with acc_clr=1, then assert i_reset one cycle later -> no o_valid after release. The next MAC 2,3 with acc_clr=0 -> o_data 0x0006.
- Idle inputs ignored: toggle A, B and op with i_valid=0 for 5 cycles -> o_valid stays 0, and the accumulator is unchanged (checked by a subsequent MAC 1,1 with acc_clr=0).
